// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - retirement trace record layout and mdata selection
package trace_pkg;

  localparam int REC_W  = 55;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  // Record layout, LSB first: mdata, maddr, wdata, wreg, then the four flags.
  localparam int MDATA_LSB = 0;
  localparam int MADDR_LSB = 16;
  localparam int WDATA_LSB = 32;
  localparam int WREG_LSB  = 48;

  localparam int FLAG_REGWRITE = 51;
  localparam int FLAG_MEMREAD  = 52;
  localparam int FLAG_MEMWRITE = 53;
  localparam int FLAG_HALT     = 54;

  typedef enum logic [1:0] {
    MSEL_NONE  = 2'd0,
    MSEL_LOAD  = 2'd1,
    MSEL_STORE = 2'd2
  } mdata_sel_e;

  // A store's data wins when a cycle reports both a load and a store.
  function automatic mdata_sel_e mdata_sel(input logic mem_read, input logic mem_write);
    mdata_sel_e sel;
    if (mem_write) begin
      sel = MSEL_STORE;
    end else if (mem_read) begin
      sel = MSEL_LOAD;
    end else begin
      sel = MSEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO with wrap-bit pointers and a registered head
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 55
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             empty_next,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    pop_ok     = pop && !empty;
    push_ok    = push && (!full || pop_ok);
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    empty_next = (wr_ptr_d == rd_ptr_d);
    // The head is preloaded from the next-state view, bypassing a push that lands in the head slot.
    head_d = '0;
    if (!empty_next) begin
      if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
        head_d = push_data;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  assign head = head_q;

endmodule

// File: rtl/retire_trace_buf.sv
// rtl/retire_trace_buf.sv - retirement trace producer: event capture, record packing,
// statistics counters and halt/overflow status in front of the trace FIFO.
module retire_trace_buf
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [2:0]        WriteRegister,
  input  logic [15:0]       WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [15:0]       MemAddress,
  input  logic [15:0]       MemDataIn,
  input  logic [15:0]       MemDataOut,
  input  logic              Halt,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [REC_W-1:0]  rec_data,
  output logic              overflow,
  output logic [7:0]        drop_count,
  output logic              halted,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count
);

  logic             overflow_q, overflow_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic             halted_q, halted_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] inst_count_q, inst_count_d;

  logic             evt;
  logic             drop;
  logic [REC_W-1:0] rec;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_empty_next;

  always_comb begin
    evt  = (Halt || RegWrite || MemRead || MemWrite) && !halted_q;
    drop = evt && fifo_full && !(rec_valid && rec_ready);

    // Fields whose flag is clear stay zero.
    rec                  = '0;
    rec[FLAG_HALT]       = Halt;
    rec[FLAG_MEMWRITE]   = MemWrite;
    rec[FLAG_MEMREAD]    = MemRead;
    rec[FLAG_REGWRITE]   = RegWrite;
    if (RegWrite) begin
      rec[WREG_LSB +: REG_W]   = WriteRegister;
      rec[WDATA_LSB +: DATA_W] = WriteData;
    end
    if (MemRead || MemWrite) begin
      rec[MADDR_LSB +: DATA_W] = MemAddress;
    end
    unique case (mdata_sel(MemRead, MemWrite))
      MSEL_STORE: rec[MDATA_LSB +: DATA_W] = MemDataIn;
      MSEL_LOAD:  rec[MDATA_LSB +: DATA_W] = MemDataOut;
      default:    rec[MDATA_LSB +: DATA_W] = '0;
    endcase
  end

  always_comb begin
    overflow_d    = overflow_q || drop;
    drop_count_d  = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
    halted_d      = halted_q || Halt;
    cycle_count_d = cycle_count_q;
    inst_count_d  = inst_count_q;
    if (!halted_q) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
      if (Halt || RegWrite || MemWrite) begin
        inst_count_d = inst_count_q + CNT_W'(1);
      end
    end
    done_d = halted_d && fifo_empty_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
      halted_q      <= 1'b0;
      done_q        <= 1'b0;
      cycle_count_q <= '0;
      inst_count_q  <= '0;
    end else begin
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
      halted_q      <= halted_d;
      done_q        <= done_d;
      cycle_count_q <= cycle_count_d;
      inst_count_q  <= inst_count_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (evt),
    .push_data  (rec),
    .pop        (rec_ready),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next),
    .head       (rec_data)
  );

  assign rec_valid   = !fifo_empty;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;
  assign halted      = halted_q;
  assign done        = done_q;
  assign cycle_count = cycle_count_q;
  assign inst_count  = inst_count_q;

endmodule

// File: tb/tb_retire_trace_buf.sv
// tb/tb_retire_trace_buf.sv - scoreboard bench for retire_trace_buf
module tb_retire_trace_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [2:0]  WriteRegister;
  logic [15:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] MemAddress;
  logic [15:0] MemDataIn;
  logic [15:0] MemDataOut;
  logic        Halt;
  logic        rec_valid;
  logic        rec_ready;
  logic [54:0] rec_data;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        halted;
  logic        done;
  logic [31:0] cycle_count;
  logic [31:0] inst_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [54:0] exp_q[$];
  logic        m_halted;
  logic        m_ovf;
  int          m_drop;
  logic [31:0] m_cyc;
  logic [31:0] m_inst;
  bit          m_evt;
  bit          m_pop;

  always #5 clk = ~clk;

  retire_trace_buf #(.DEPTH(8), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemAddress    (MemAddress),
    .MemDataIn     (MemDataIn),
    .MemDataOut    (MemDataOut),
    .Halt          (Halt),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_data      (rec_data),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .halted        (halted),
    .done          (done),
    .cycle_count   (cycle_count),
    .inst_count    (inst_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [54:0] pack(input logic rw, input logic [2:0] wr, input logic [15:0] wd,
                                       input logic mr, input logic mw, input logic [15:0] ma,
                                       input logic [15:0] mi, input logic [15:0] mo, input logic h);
    logic [15:0] md;
    md = mw ? mi : (mr ? mo : 16'h0);
    return {h, mw, mr, rw, rw ? wr : 3'd0, rw ? wd : 16'h0, (mr || mw) ? ma : 16'h0, md};
  endfunction

  // Reference model: expected records enter the queue at the push edge and leave at the pop edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_halted = 1'b0;
      m_ovf    = 1'b0;
      m_drop   = 0;
      m_cyc    = '0;
      m_inst   = '0;
    end else begin
      m_evt = (Halt || RegWrite || MemRead || MemWrite) && !m_halted;
      m_pop = rec_ready && (exp_q.size() > 0);
      if (!m_halted) begin
        m_cyc++;
        if (Halt || RegWrite || MemWrite) m_inst++;
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_evt) begin
        if (exp_q.size() < 8) begin
          exp_q.push_back(pack(RegWrite, WriteRegister, WriteData, MemRead, MemWrite,
                               MemAddress, MemDataIn, MemDataOut, Halt));
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (Halt) m_halted = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("rec_valid", rec_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) check("rec_data", rec_data, exp_q[0]);
      check("cycle_count", cycle_count, m_cyc);
      check("inst_count", inst_count, m_inst);
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drop);
      check("halted", halted, m_halted);
      check("done", done, m_halted && (exp_q.size() == 0));
    end
  end

  task automatic step(input logic rw, input logic [2:0] wr, input logic [15:0] wd,
                      input logic mr, input logic mw, input logic [15:0] ma,
                      input logic [15:0] mi, input logic [15:0] mo, input logic h);
    RegWrite      = rw;
    WriteRegister = wr;
    WriteData     = wd;
    MemRead       = mr;
    MemWrite      = mw;
    MemAddress    = ma;
    MemDataIn     = mi;
    MemDataOut    = mo;
    Halt          = h;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    rec_ready = 1'b0;
    idle(1);
    do_reset();
    check("reset rec_valid", rec_valid, 0);
    check("reset rec_data", rec_data, 0);
    check("reset done", done, 0);
    check("reset cycle_count", cycle_count, 0);

    // Single register write.
    rec_ready = 1'b1;
    step(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    check("regwrite record", rec_data, {1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234, 16'h0, 16'h0});
    idle(3);
    check("regwrite inst_count", inst_count, 1);

    // Load with reg write, then a store, then a load-only cycle.
    do_reset();
    rec_ready = 1'b1;
    step(1'b1, 3'd5, 16'hBEEF, 1'b1, 1'b0, 16'h0040, 16'h0, 16'hBEEF, 1'b0);
    check("load record", rec_data, {1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 16'hBEEF, 16'h0040, 16'hBEEF});
    step(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'h0042, 16'h00AA, 16'h0, 1'b0);
    check("store record", rec_data, {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0042, 16'h00AA});
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 16'h0050, 16'h0, 16'h7777, 1'b0);
    idle(3);
    check("ldst inst_count", inst_count, 2);

    // Overflow: 10 writes into an 8-deep FIFO with the reader stalled.
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'(i), 16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    end
    check("ovf overflow", overflow, 1);
    check("ovf drop_count", drop_count, 2);
    check("ovf inst_count", inst_count, 10);
    check("ovf head", rec_data, {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0100, 16'h0, 16'h0});
    rec_ready = 1'b1;
    idle(10);
    check("ovf drained", rec_valid, 0);

    // Full FIFO with simultaneous push and pop every cycle.
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 16'h0200 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    end
    rec_ready = 1'b1;
    for (int i = 8; i < 20; i++) begin
      step(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'h0300 + 16'(i), 16'h0A00 + 16'(i), 16'h0, 1'b0);
    end
    idle(10);
    check("fullpp drop_count", drop_count, 0);
    check("fullpp overflow", overflow, 0);

    // Halt on the 20th cycle after reset, followed by ignored writes.
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'(i), 16'h0400 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    end
    idle(14);
    step(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd7, 16'hDEAD, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    end
    check("halt halted", halted, 1);
    check("halt cycle_count", cycle_count, 20);
    check("halt inst_count", inst_count, 6);
    check("halt done early", done, 0);
    rec_ready = 1'b1;
    idle(8);
    check("halt done", done, 1);
    check("halt cycle frozen", cycle_count, 20);

    // Reset while records are queued.
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'(i), 16'h0500 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst rec_valid", rec_valid, 0);
    check("midrst inst_count", inst_count, 0);
    check("midrst cycle_count", cycle_count, 0);
    check("midrst overflow", overflow, 0);
    check("midrst halted", halted, 0);
    rec_ready = 1'b1;
    step(1'b1, 3'd6, 16'hCAFE, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    check("midrst record", rec_data, {1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 16'hCAFE, 16'h0, 16'h0});
    idle(3);
    check("midrst sole record", rec_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
